// File: rtl/seq_detect_prog_if.sv
// Bundle of the serial-data, configuration and result signals of seq_detect_prog.
// master: the side that supplies bits and configuration; slave: the detector.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             inp_bit;
    logic             inp_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             seq_seen;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  seq_seen, match_cnt
    );

    modport slave (
        input  inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output seq_seen, match_cnt
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector.
// A PAT_W-bit history register collects valid bits (newest in the LSB) together with a
// fill count; a match fires when at least len bits have been collected and the low len
// history bits equal the programmed pattern. Overlap mode keeps the history after a
// match, non-overlap mode restarts the fill count so a new match needs len fresh bits.
// Optional feature: define SEQ_DETECT_CNT_EN to build the saturating match counter;
// without it match_cnt reads 0 and cnt_clr has no effect.
module seq_detect_prog #(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0000_1011),
    parameter int               DEF_LEN = 4
) (
    input  logic               clk,
    input  logic               reset,
    seq_detect_prog_if.slave   bus
);
    localparam int               LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic             seen_q;

    logic [PAT_W-1:0] hist_shift;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_inc;
    logic [LEN_W-1:0] cfg_len_clamped;
    logic             accept;
    logic             match;

    // Candidate next history/fill for an accepted bit and the resulting match decision.
    // A bit arriving together with cfg_load is dropped, so it can never match.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hist_shift = {hist_q[PAT_W-2:0], bus.inp_bit};
        fill_inc   = (fill_q == LEN_MAX) ? LEN_MAX : fill_q + LEN_W'(1);
        accept     = bus.inp_valid && !bus.cfg_load;
        match      = accept && (fill_inc >= len_q)
                     && (((hist_shift ^ pat_q) & len_mask) == '0);
    end

    // Out-of-range lengths are folded into 1..PAT_W so the mask is never empty.
    always_comb begin
        cfg_len_clamped = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (bus.cfg_len > LEN_MAX) begin
            cfg_len_clamped = LEN_MAX;
        end
    end

    // Configuration, history, fill count and the registered match pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= 1'b1;
            seen_q <= 1'b0;
        end else begin
            seen_q <= match;
            if (bus.cfg_load) begin
                hist_q <= '0;
                fill_q <= '0;
                pat_q  <= bus.cfg_pattern;
                len_q  <= cfg_len_clamped;
                ovl_q  <= bus.cfg_overlap;
            end else if (accept) begin
                hist_q <= hist_shift;
                fill_q <= (match && !ovl_q) ? '0 : fill_inc;
            end
        end
    end

    assign bus.seq_seen = seen_q;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter; a clear coinciding with a match counts that match.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_W, default 8, SHALL set the maximum pattern length in bits (2..32).
REQ-002 Parameter CNT_W, default 8, SHALL set the match counter width.
REQ-003 Parameter DEF_PAT, default 8'b0000_1011, SHALL set the pattern loaded at reset, right-aligned.
REQ-004 Parameter DEF_LEN, default 4, SHALL set the pattern length loaded at reset.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 inp_bit  input  1  SHALL carry the serial data bit.
REQ-008 inp_valid  input  1  SHALL qualify inp_bit; the bit is sampled only when high.
REQ-009 cfg_load  input  1  SHALL be a one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
REQ-010 cfg_pattern  input  PAT_W  SHALL be the new pattern, right-aligned; bit [len-1] is the first bit received.
REQ-011 cfg_len  input  $clog2(PAT_W+1)  SHALL be the new pattern length.
REQ-012 cfg_overlap  input  1  SHALL select overlapping detection when 1 and non-overlapping detection when 0.
REQ-013 cnt_clr  input  1  SHALL be a strobe that clears match_cnt.
REQ-014 seq_seen  output  1  SHALL be a registered one-cycle match pulse.
REQ-015 match_cnt  output  CNT_W  SHALL report the saturating count of matches.

Function
REQ-016 The block SHALL keep a PAT_W-bit history shift register and a fill counter of valid bits accumulated since the last clear; the fill counter saturates at PAT_W.
REQ-017 Each accepted bit SHALL shift into the history LSB and increment the fill counter.
REQ-018 A match SHALL occur on an accepted bit when fill (including that bit) >= len and history[len-1:0] == pattern[len-1:0].
REQ-019 On a match, seq_seen SHALL be 1 for exactly the cycle after the accepting edge; otherwise it SHALL be 0, including on cycles with no valid bit.
REQ-020 Overlap mode SHALL leave the history and fill counter unchanged after a match.
REQ-021 Non-overlap mode SHALL clear the fill counter to 0 on the matching edge, so no bit of a match contributes to the next match.
REQ-022 cfg_len of 0 SHALL be stored as 1; cfg_len > PAT_W SHALL be stored as PAT_W.
REQ-023 cfg_load SHALL clear the history and fill counter; a bit presented in the same cycle SHALL be discarded and SHALL NOT produce a match.
REQ-024 seq_seen SHALL be 0 in the cycle after cfg_load; match_cnt SHALL be preserved across cfg_load.
REQ-025 match_cnt SHALL increment on each match and hold at 2^CNT_W-1 once saturated.
REQ-026 cnt_clr together with a match in the same cycle SHALL yield match_cnt = 1; cnt_clr alone SHALL yield 0.

Reset
REQ-027 Reset SHALL set history = 0, fill = 0, seq_seen = 0, match_cnt = 0, pattern = DEF_PAT, len = DEF_LEN and overlap = 1.
REQ-028 Reset SHALL take priority over cfg_load, cnt_clr and inp_valid; a partial sequence in progress SHALL be discarded.

Configuration
REQ-029 With macro SEQ_DETECT_CNT_EN defined, the match counter of REQ-025/026 SHALL be implemented.
REQ-030 Without SEQ_DETECT_CNT_EN, match_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, and no counter flops SHALL exist; all other behaviour is unchanged.

Verification
REQ-031 Reset defaults (1011, overlap) with valid bits 1,0,1,1,0,1,1 -> seq_seen pulses after bits 4 and 7; match_cnt = 2.
REQ-032 Load pattern 111, len 3, overlap 0 with bits 1,1,1,1,1,1 -> pulses after bits 3 and 6 only; with overlap 1 -> pulses after bits 3, 4, 5 and 6.
REQ-033 Defaults with bits 1,0,1, then reset, then bit 1 -> no pulse; match_cnt = 0.
REQ-034 Defaults with bits 1,0,1,1 interleaved with inp_valid = 0 gaps of 1-3 cycles -> exactly one pulse, the cycle after the fourth valid bit.
REQ-035 CNT_W = 4 with 20 overlapping matches -> match_cnt = 15; cnt_clr on a match cycle -> match_cnt = 1.
REQ-036 cfg_load (pattern 10, len 2) in the same cycle as the final 1 of 1011 -> no pulse; the following bits 1,0 -> one pulse.
